// File: rtl/bounce_generator.sv
// bounce_generator: mechanical push-button emulator driving a debouncer input.
//
// A clean level request arrives over a valid/ready handshake. When the requested
// level differs from the present output, b_o jumps to the target and then bounces
// through a pseudo-random number of glitch pairs with pseudo-random phase lengths.
// It then holds the target for SETTLE cycles and raises done_o for one cycle.
// A request for the level already on b_o completes at once, with no edges on b_o.
//
// Parameters:
//   BOUNCE_MAX  maximum glitch pairs per transition (0..15)
//   LEN_LOG2    each bounce phase lasts 1..2^LEN_LOG2 cycles
//   SETTLE      stable cycles after the final edge before done_o (>= 1)
//   SEED        LFSR reset value (0 is replaced by 16'h0001)
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request present
//   req_level_i  requested final level of b_o, sampled only at accept
//   req_ready_o  high only while idle
//   b_o          registered bouncy button output
//   busy_o       high while bouncing or settling
//   done_o       one-cycle registered completion pulse
//   edge_cnt_o   (BOUNCE_STATS_EN only) saturating count of b_o edges since the last accept
//
// Optional feature macro: BOUNCE_STATS_EN adds edge_cnt_o.

module bounce_generator #(
   parameter int unsigned BOUNCE_MAX = 4,
   parameter int unsigned LEN_LOG2   = 3,
   parameter int unsigned SETTLE     = 20,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   input  logic       req_level_i,
   output logic       req_ready_o,
   output logic       b_o,
   output logic       busy_o,
   output logic       done_o
`ifdef BOUNCE_STATS_EN
   ,
   output logic [7:0] edge_cnt_o
`endif
);

   localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   // One down-counter serves both the phase lengths and the settle period.
   localparam int unsigned CntW    = (SettleW > LEN_LOG2) ? SettleW : LEN_LOG2;

   localparam logic [15:0]     SeedEff    = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [3:0]      BounceMax  = 4'(BOUNCE_MAX);
   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBounceOn,
      StBounceOff,
      StSettle
   } state_e;

   state_e            state_q, state_d;
   logic              b_q, b_d;
   logic              tgt_q, tgt_d;
   logic              done_q, done_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [3:0]        pairs_q, pairs_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic              accept;
   logic [3:0]        n_pick;
   logic [CntW-1:0]   len_load;

   assign accept   = req_valid_i & (state_q == StIdle);
   assign n_pick   = (lfsr_q[3:0] > BounceMax) ? BounceMax : lfsr_q[3:0];
   // Counter holds (phase length - 1), so the raw LFSR bits load directly.
   assign len_load = CntW'(lfsr_q[LEN_LOG2-1:0]);

   // Galois LFSR, free-running whenever out of reset.
   assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      tgt_d   = tgt_q;
      pairs_d = pairs_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_level_i != b_q) begin
                  b_d     = req_level_i;
                  tgt_d   = req_level_i;
                  pairs_d = n_pick;
                  if (n_pick == 4'd0) begin
                     state_d = StSettle;
                     cnt_d   = SettleLoad;
                  end else begin
                     state_d = StBounceOn;
                     cnt_d   = len_load;
                  end
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         StBounceOn: begin
            if (cnt_q == '0) begin
               b_d     = ~tgt_q;
               state_d = StBounceOff;
               cnt_d   = len_load;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         StBounceOff: begin
            if (cnt_q == '0) begin
               b_d     = tgt_q;
               pairs_d = pairs_q - 4'd1;
               if (pairs_q == 4'd1) begin
                  state_d = StSettle;
                  cnt_d   = SettleLoad;
               end else begin
                  state_d = StBounceOn;
                  cnt_d   = len_load;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         StSettle: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         b_q     <= 1'b0;
         tgt_q   <= 1'b0;
         done_q  <= 1'b0;
         lfsr_q  <= SeedEff;
         pairs_q <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         tgt_q   <= tgt_d;
         done_q  <= done_d;
         lfsr_q  <= lfsr_d;
         pairs_q <= pairs_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign b_o         = b_q;
   assign done_o      = done_q;

`ifdef BOUNCE_STATS_EN
   logic [7:0] edge_cnt_q, edge_cnt_d;

   // Cleared on accept, then the accept's own edge (if any) is counted.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      if (accept) begin
         edge_cnt_d = 8'd0;
      end
      if ((b_d != b_q) && (edge_cnt_d != 8'hFF)) begin
         edge_cnt_d = edge_cnt_d + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         edge_cnt_q <= 8'd0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign edge_cnt_o = edge_cnt_q;
`endif

endmodule
